// File: rtl/ps2_rx_ctrl_pkg.sv
// ps2_rx_ctrl_pkg: shared PS/2 frame constants, receiver FSM states and parity helper.
package ps2_rx_ctrl_pkg;
  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS = 8;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;
  function automatic logic odd_ok(input logic [PS2_DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction
endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: show-ahead sync FIFO; head output holds the last popped byte when empty.
module ps2_rx_fifo
  import ps2_rx_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [PS2_DATA_BITS-1:0] din,
  output logic [PS2_DATA_BITS-1:0] dout,
  output logic                     full,
  output logic                     empty,
  output logic [AW:0]              cnt
);
  localparam int CW = AW + 1;
  logic [PS2_DATA_BITS-1:0] mem [DEPTH];
  logic [PS2_DATA_BITS-1:0] last;
  logic [AW-1:0] wptr, rptr;
  logic push_ok, pop_ok;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign pop_ok = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout = empty ? last : mem[rptr];
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      last <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok) begin
        rptr <= rptr + 1'b1;
        last <= mem[rptr];
      end
      cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
    end
  end
  always_ff @(posedge clock) begin
    if (push_ok) mem[wptr] <= din;
  end
endmodule

// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl: PS/2 host receiver -- synchronisers, falling-edge frame FSM with timeout,
// scancode FIFO and sticky overflow/frame error flags.
module ps2_rx_ctrl
  import ps2_rx_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW = 3,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     ps2_clk,
  input  logic                     ps2_dat,
  input  logic                     rd_en,
  output logic [PS2_DATA_BITS-1:0] rd_data,
  output logic                     rd_valid,
  output logic [FIFO_AW:0]         fifo_cnt,
  input  logic                     clr_err,
  output logic                     overflow,
  output logic                     frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int BW = $clog2(PS2_DATA_BITS);
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic clk_q, fall, dat;
  ps2_state_e state, state_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [PS2_DATA_BITS-1:0] sr, sr_n;
  logic ok, ok_n, push, ferr_set, ovf_set, timeout, full, empty;
  logic [TW-1:0] idle_cnt;
  assign fall = clk_q & ~clk_sync[SYNC_STAGES-1];
  assign dat = dat_sync[SYNC_STAGES-1];
  assign timeout = state != IDLE && idle_cnt == TW'(TIMEOUT_CYC - 1);
  assign ovf_set = push & full & ~rd_en;
  assign rd_valid = ~empty;
  // Synchronisers reset to 1 so a released reset never looks like a clock fall.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_q <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
      clk_q <= clk_sync[SYNC_STAGES-1];
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      bit_cnt <= '0;
      sr <= '0;
      ok <= 1'b0;
      idle_cnt <= '0;
      overflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= bit_cnt_n;
      sr <= sr_n;
      ok <= ok_n;
      idle_cnt <= fall ? '0 : idle_cnt == TW'(TIMEOUT_CYC - 1) ? idle_cnt : idle_cnt + 1'b1;
      overflow <= ovf_set | (overflow & ~clr_err);
      frame_err <= ferr_set | (frame_err & ~clr_err);
    end
  end
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    sr_n = sr;
    ok_n = ok;
    push = 1'b0;
    ferr_set = 1'b0;
    if (fall) begin
      unique case (state)
        IDLE: begin
          state_n = dat ? IDLE : DATA;
          bit_cnt_n = '0;
        end
        DATA: begin
          sr_n = {dat, sr[PS2_DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          state_n = bit_cnt == BW'(PS2_DATA_BITS - 1) ? PARITY : DATA;
        end
        PARITY: begin
          ok_n = odd_ok(sr, dat);
          state_n = STOP;
        end
        STOP: begin
          push = dat & ok;
          ferr_set = ~(dat & ok);
          state_n = IDLE;
        end
      endcase
    end else if (timeout) begin
      state_n = IDLE;
      sr_n = '0;
      ferr_set = 1'b1;
    end
  end
  ps2_rx_fifo #(.DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_fifo (
    .clock (clock),
    .resetn(resetn),
    .push  (push),
    .pop   (rd_en),
    .din   (sr),
    .dout  (rd_data),
    .full  (full),
    .empty (empty),
    .cnt   (fifo_cnt)
  );
endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// tb_ps2_rx_ctrl: directed PS/2 frames against a queue-based scancode/flag model,
// checked every quiet cycle plus literal spot checks.
module tb_ps2_rx_ctrl;
  localparam int TIMEOUT = 2000;
  logic clock = 0, resetn = 0, ps2_clk = 1, ps2_dat = 1, rd_en = 0, clr_err = 0;
  logic [7:0] rd_data;
  logic rd_valid, overflow, frame_err;
  logic [3:0] fifo_cnt;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  logic [7:0] q[$];
  logic [7:0] exp_last = 0;
  bit exp_ovf = 0, exp_ferr = 0;

  ps2_rx_ctrl dut (
    .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .fifo_cnt(fifo_cnt),
    .clr_err(clr_err), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en && resetn) begin
      check("m_valid", int'(rd_valid), int'(q.size() != 0));
      check("m_data", int'(rd_data), int'(q.size() != 0 ? q[0] : exp_last));
      check("m_cnt", int'(fifo_cnt), q.size());
      check("m_ovf", int'(overflow), int'(exp_ovf));
      check("m_ferr", int'(frame_err), int'(exp_ferr));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Sends the first nbits bits of a frame; odd parity unless bad_par.
  task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                      input bit pop_stop, input int nbits);
    logic [10:0] fr;
    bit popped;
    chk_en = 0;
    fr = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      tick(10);
      ps2_clk = 0;
      if (pop_stop && i == 10) begin
        tick(2);
        rd_en = 1;
        tick(1);
        rd_en = 0;
        tick(7);
      end else tick(10);
      ps2_clk = 1;
    end
    ps2_dat = 1;
    tick(30);
    if (nbits == 11) begin
      popped = pop_stop && q.size() != 0;
      if (popped) exp_last = q.pop_front();
      if (bad_par || bad_stop) exp_ferr = 1;
      else if (q.size() < 8) q.push_back(d);
      else exp_ovf = 1;
    end
    chk_en = 1;
  endtask

  task automatic pop();
    chk_en = 0;
    rd_en = 1;
    tick(1);
    rd_en = 0;
    if (q.size() != 0) exp_last = q.pop_front();
    chk_en = 1;
    tick(1);
  endtask

  task automatic clr();
    chk_en = 0;
    clr_err = 1;
    tick(1);
    clr_err = 0;
    exp_ovf = 0;
    exp_ferr = 0;
    chk_en = 1;
    tick(1);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_valid"}, int'(rd_valid), 0);
    check({tag, "_data"}, int'(rd_data), 0);
    check({tag, "_cnt"}, int'(fifo_cnt), 0);
    check({tag, "_ovf"}, int'(overflow), 0);
    check({tag, "_ferr"}, int'(frame_err), 0);
  endtask

  initial begin
    tick(3);
    reset_checks("rst");
    resetn = 1;
    tick(2);
    chk_en = 1;
    // basic frame and pop
    send(8'h1C, 0, 0, 0, 11);
    check("t1_valid", int'(rd_valid), 1);
    check("t1_data", int'(rd_data), 'h1C);
    check("t1_cnt", int'(fifo_cnt), 1);
    pop();
    check("t1_cnt_pop", int'(fifo_cnt), 0);
    check("t1_hold", int'(rd_data), 'h1C);
    // parity error
    send(8'h1C, 1, 0, 0, 11);
    check("t2_ferr", int'(frame_err), 1);
    check("t2_cnt", int'(fifo_cnt), 0);
    clr();
    check("t2_clr", int'(frame_err), 0);
    send(8'h3A, 0, 1, 0, 11);
    check("t2_stop_ferr", int'(frame_err), 1);
    clr();
    // clock toggling with data idle high
    ps2_dat = 1;
    for (int i = 0; i < 20; i++) begin
      tick(10);
      ps2_clk = ~ps2_clk;
    end
    tick(30);
    check("t3_cnt", int'(fifo_cnt), 0);
    check("t3_ferr", int'(frame_err), 0);
    // overflow
    for (int i = 1; i <= 9; i++) send(8'(i), 0, 0, 0, 11);
    check("t4_cnt", int'(fifo_cnt), 8);
    check("t4_ovf", int'(overflow), 1);
    for (int i = 1; i <= 8; i++) begin
      check("t4_pop", int'(rd_data), i);
      pop();
    end
    check("t4_empty", int'(rd_valid), 0);
    clr();
    check("t4_ovf_clr", int'(overflow), 0);
    // timeout after start + 4 data bits
    send(8'hA5, 0, 0, 0, 5);
    chk_en = 0;
    tick(TIMEOUT - 200);
    check("t5_early", int'(frame_err), 0);
    tick(400);
    exp_ferr = 1;
    check("t5_ferr", int'(frame_err), 1);
    chk_en = 1;
    clr();
    send(8'hF0, 0, 0, 0, 11);
    check("t5_data", int'(rd_data), 'hF0);
    check("t5_ferr_after", int'(frame_err), 0);
    pop();
    // full FIFO with pop coincident with push
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 0, 0, 0, 11);
    check("t6_full", int'(fifo_cnt), 8);
    send(8'h77, 0, 0, 1, 11);
    check("t6_cnt", int'(fifo_cnt), 8);
    check("t6_ovf", int'(overflow), 0);
    check("t6_head", int'(rd_data), 'h11);
    // reset mid-frame
    send(8'hC3, 0, 0, 0, 4);
    chk_en = 0;
    resetn = 0;
    q.delete();
    exp_last = 0;
    exp_ovf = 0;
    exp_ferr = 0;
    tick(1);
    reset_checks("t6_rst");
    resetn = 1;
    tick(2);
    chk_en = 1;
    send(8'h5A, 0, 0, 0, 11);
    check("t6_new", int'(rd_data), 'h5A);
    check("t6_new_cnt", int'(fifo_cnt), 1);
    pop();
    tick(10);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
